joy_db15_responder: RTL
=======================

// Module: joy_db15_responder
// PURPOSE
//  Device end of the DB15 serial joystick link: emulates the adapter's parallel-in/serial-out shift chain.
//  Latches two 16-bit button words on joy_load low, then presents one bit per joy_clk rising edge on joy_data.
//  Counterpart to the joy_db15 reader; used for loopback test cores and for bridging USB pads onto UserIO.
//  Runs on the core clock (clk_50 class); joy_clk/joy_load are asynchronous pin inputs.
// PARAMETERS
//  CHAIN_BITS   32   total chain length; bits [15:0]=joystick1, [31:16]=joystick2; values >32 pad with 1s
//  SYNC_STAGES  2    synchronizer depth on joy_clk/joy_load (min 2)
//  TIMEOUT      4096 clk cycles without a joy_clk edge before a frame is abandoned (JOYDB15_RESP_TIMEOUT_EN only)
// PORTS
//  clk          in   1   core clock; all logic on posedge
//  reset        in   1   synchronous, active-high
//  joystick1    in   16  player 1 buttons, active-high (1=pressed), ----LS FEDCBAUDLR layout
//  joystick2    in   16  player 2 buttons, same layout
//  joy_clk      in   1   async shift clock from reader; shifts on rising edge
//  joy_load     in   1   async load strobe from reader, active-low
//  joy_data     out  1   serial data to reader, active-low buttons (0=pressed)
//  frame_done   out  1   one-clk pulse when the last chain bit has been shifted out
//  bit_count    out  6   number of shifts since last load, saturates at CHAIN_BITS
// BEHAVIOUR
//  Sync: joy_clk, joy_load each pass SYNC_STAGES flops; joy_clk rise = sync[last] & ~prev.
//  Reset: sr <= all 1s, joy_data=1, frame_done=0, bit_count=0, state=IDLE.
//  Load image L = {pad 1s, ~joystick2, ~joystick1}; joy_data = sr[0]; shift right, fill MSB with 1.
//  States:
//   IDLE    : joy_data=1. joy_load_s==0 -> LOAD.
//   LOAD    : sr <= L every clk while joy_load_s==0 (transparent, as 74HC165); bit_count<=0;
//             joy_load_s==1 -> SHIFT. joy_clk edges ignored while in LOAD.
//   SHIFT   : on joy_clk rise: sr <= {1'b1, sr[CHAIN_BITS-1:1]}, bit_count++;
//             when bit_count reaches CHAIN_BITS -> frame_done pulse, state DONE.
//             joy_load_s==0 at any time -> LOAD (restart; no frame_done).
//   DONE    : joy_data=1; further joy_clk rises ignored, bit_count holds CHAIN_BITS; joy_load_s==0 -> LOAD.
//  Latency: pin edge -> joy_data change = SYNC_STAGES+1 clk; reader must hold each joy_clk phase
//   > SYNC_STAGES+2 clk periods.
//  Simultaneous: load low and clk rise in same cycle -> load wins, no shift.
//  Input change during SHIFT does not affect sr (snapshot taken at load release).
//  Reset mid-frame: immediate return to IDLE, joy_data=1 next clk.
//  bit_count width fixed 6; CHAIN_BITS>63 is unsupported.
// CONFIGURATION
//  JOYDB15_RESP_TIMEOUT_EN defined: watchdog counter cleared on each joy_clk rise or load;
//   in SHIFT, TIMEOUT clk cycles without an edge -> state IDLE, sr<=all 1s, joy_data=1, no frame_done.
//  Undefined: no watchdog; SHIFT waits indefinitely for joy_clk; TIMEOUT parameter unused.
// TESTING
//  1 joystick1=16'h0011, joystick2=0, load pulse, 32 clk edges -> joy_data bits 0,1,1,1,0,1..1; frame_done once after edge 32.
//  2 joystick2=16'h8000, joystick1=0 -> bit 31 out = 0, all others 1; bit_count=32 at end; edges 33..40 give joy_data=1.
//  3 load re-asserted after 10 edges -> bit_count=0, next frame restarts at joystick1[0]; no frame_done for aborted frame.
//  4 change joystick1 0->16'hFFFF after load release -> shifted word still all 1s (snapshot honoured).
//  5 reset asserted at edge 5 -> joy_data=1, bit_count=0, IDLE next clk; next load/shift frame correct.
//  6 JOYDB15_RESP_TIMEOUT_EN, TIMEOUT=64, stop joy_clk after edge 7 -> at 64 clk idle, joy_data=1, state IDLE, frame_done=0.

Source files
------------

// File: rtl/joy_db15_responder.sv
// Device end of the DB15 serial joystick link: parallel-in/serial-out shift chain driven by async joy_clk/joy_load pins.
// Optional frame watchdog enabled by defining JOYDB15_RESP_TIMEOUT_EN.
module joy_db15_responder #(
    parameter int CHAIN_BITS  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        joy_data,
    output logic        frame_done,
    output logic [5:0]  bit_count
);

    localparam logic [5:0] CHAIN_LAST = 6'(CHAIN_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0]  load_sync_q, load_sync_d;
    logic                    clk_prev_q, clk_prev_d;
    logic [CHAIN_BITS-1:0]   sr_q, sr_d;
    logic [5:0]              bit_count_q, bit_count_d;
    logic                    frame_done_q, frame_done_d;
    logic                    joy_data_q, joy_data_d;
    logic [CHAIN_BITS-1:0]   load_image;
    logic                    clk_rise;
    logic                    load_s;

`ifdef JOYDB15_RESP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    // Chain bits beyond the two button words read as released (1).
    always_comb begin
        load_image = '1;
        for (int unsigned i = 0; i < CHAIN_BITS; i++) begin
            if (i < 16)
                load_image[i] = ~joystick1[i[3:0]];
            else if (i < 32)
                load_image[i] = ~joystick2[i[3:0]];
        end
    end

    assign clk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign load_s   = load_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
        load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], joy_load};
        clk_prev_d   = clk_sync_q[SYNC_STAGES-1];
        state_d      = state_q;
        sr_d         = sr_q;
        bit_count_d  = bit_count_q;
        frame_done_d = 1'b0;
`ifdef JOYDB15_RESP_TIMEOUT_EN
        wd_d         = '0;
`endif

        // Load strobe overrides everything, including a coincident shift edge.
        if (!load_s) begin
            state_d     = S_LOAD;
            sr_d        = load_image;
            bit_count_d = '0;
        end else begin
            case (state_q)
                S_LOAD: state_d = S_SHIFT;
                S_SHIFT: begin
                    if (clk_rise) begin
                        sr_d        = {1'b1, sr_q[CHAIN_BITS-1:1]};
                        bit_count_d = bit_count_q + 6'd1;
                        if (bit_count_q == CHAIN_LAST) begin
                            frame_done_d = 1'b1;
                            state_d      = S_DONE;
                        end
                    end
`ifdef JOYDB15_RESP_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        state_d = S_IDLE;
                        sr_d    = '1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end

        joy_data_d = (state_d == S_LOAD || state_d == S_SHIFT) ? sr_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            clk_sync_q   <= '0;
            load_sync_q  <= '1;
            clk_prev_q   <= 1'b0;
            sr_q         <= '1;
            bit_count_q  <= '0;
            frame_done_q <= 1'b0;
            joy_data_q   <= 1'b1;
`ifdef JOYDB15_RESP_TIMEOUT_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            load_sync_q  <= load_sync_d;
            clk_prev_q   <= clk_prev_d;
            sr_q         <= sr_d;
            bit_count_q  <= bit_count_d;
            frame_done_q <= frame_done_d;
            joy_data_q   <= joy_data_d;
`ifdef JOYDB15_RESP_TIMEOUT_EN
            wd_q         <= wd_d;
`endif
        end
    end

    assign joy_data   = joy_data_q;
    assign frame_done = frame_done_q;
    assign bit_count  = bit_count_q;

endmodule
